seg7_scan_scheduler: RTL and testbench
======================================

Name: seg7_scan_scheduler

Overview:
Multiplexed-display scheduler that drives the chained-595 shifter in the 7-segment clock. It cycles through NUM_DIGITS digit slots. For each slot it does four things: decodes a 4-bit digit value to a segment pattern, builds a 16-bit shift word, triggers the shifter, and waits for the shifter's latch indication. It then holds the slot for a fixed dwell time. New digit values are double-buffered and committed only at frame boundaries, so the display never shows a torn frame.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
DWELL_CYCLES, 1000, clk_i cycles each digit stays lit after its latch (>=1)
TIMEOUT_CYCLES, 64, max cycles to wait for shifter completion after trigger (>=4)
COMMON_ANODE, 0, 1 inverts all 16 bits of the shift word (active-low segments and digit selects)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
enable_i  input  1  scanning enable
digits_i  input  4*NUM_DIGITS  digit values; nibble i drives digit i (0x0-0xF)
dp_i  input  NUM_DIGITS  decimal point per digit
update_i  input  1  request to commit digits_i/dp_i into the display buffer
update_ack_o  output  1  one-cycle pulse when the commit happens
shift_trigger_o  output  1  one-cycle start pulse to the shifter
shift_data_o  output  16  word to shift; [15:8] = {dp,g,f,e,d,c,b,a}, [7:0] = one-hot digit select
shift_done_i  input  1  shifter latch-enable output (high = idle/latched)
digit_idx_o  output  3  current slot index
frame_done_o  output  1  one-cycle pulse after the last digit's dwell completes
timeout_err_o  output  1  sticky: shifter failed to complete within TIMEOUT_CYCLES

Behaviour:
- Reset (async, rst_ni=0): every output is 0, including shift_data_o, even when COMMON_ANODE=1. State=IDLE, idx=0, display buffer all zero, counters 0.
- Decode table (gfedcba, a=bit0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Word for slot i: {dp_buf[i], decode(digit_buf[i])} in bits [15:8]; bit i of [7:0] set, all other bits 0. The whole word is inverted if COMMON_ANODE=1.
- Blank word: 16'h0000 (COMMON_ANODE=0) or 16'hFFFF (COMMON_ANODE=1).
- FSM states: IDLE, LOAD, WAIT_LOW, WAIT_HIGH, DWELL, BLANK.
  - IDLE: if update_i=1, commit the buffer and pulse ack. If enable_i=1, go to LOAD with idx=0.
  - LOAD (1 cycle): shift_data_o registered with the slot word; shift_trigger_o=1 in this same cycle; then go to WAIT_LOW. shift_data_o stays stable until the next LOAD or BLANK.
  - WAIT_LOW: wait for shift_done_i=0 (shifter has started).
  - WAIT_HIGH: wait for shift_done_i=1 (latched), then go to DWELL with the counter cleared.
  - The timeout counter runs from the cycle after the trigger across WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT_CYCLES: set timeout_err_o, then proceed to DWELL. timeout_err_o is cleared only by reset.
  - DWELL: count DWELL_CYCLES cycles.
    - If idx<NUM_DIGITS-1: idx+1, go to LOAD.
    - Else: pulse frame_done_o, idx=0. In the same cycle, if update_i=1, commit and pulse update_ack_o. Then go to LOAD if enable_i=1, else BLANK.
  - BLANK: drive the blank word, pulse trigger, wait for completion (same wait/timeout rules), then go to IDLE.
- enable_i deasserted mid-frame: the frame continues until its end. enable_i is sampled only in IDLE and at end of frame.
- update_i held continuously: one commit per frame boundary. digits_i changes outside a commit are never shown.
- Commit and frame end in the same cycle: the new values are used from digit 0 of the next frame.
- Latency: enable_i rises in IDLE at cycle T → trigger at T+1. Slot period = 1 + shift time + DWELL_CYCLES + 2 handshake cycles.
- Reset mid-operation: immediate return to the reset state. The trigger is dropped that cycle.

Test Plan:
- Reset mid-WAIT_HIGH → all outputs 0 asynchronously; after release with enable_i=1, the first trigger comes 1 cycle after enable_i is sampled and idx=0.
- NUM_DIGITS=4, buffer 0x1234 (digit0=4), dp=0, COMMON_ANODE=0, shifter model with 33-cycle shift → words 16'h6601, 16'h4F02, 16'h5B04, 16'h0608 in order, each followed by exactly DWELL_CYCLES of dwell; frame_done_o pulses once per frame.
- update_i pulsed mid-frame with 0xABCD, dp=4'b0001 → no change until frame end; ack coincides with frame_done_o; next frame's first word is 16'hDE01.
- shift_done_i tied high (shifter never starts) → timeout_err_o set TIMEOUT_CYCLES after the trigger; scanning continues; the flag stays set until reset.
- enable_i dropped during digit 1 → digits 2 and 3 are still shown, then the blank word 16'h0000 is triggered, then IDLE with no further triggers.
- COMMON_ANODE=1, digit value 8, dp=1, slot 0 → shift_data_o=16'h00FE; blank word is 16'hFFFF.

Source files
------------

// File: rtl/seg7_scan_scheduler.sv
// Scan scheduler for a multiplexed 7-segment display behind a chained-595 shifter.
// Per digit slot: decode, build word, trigger shifter, await latch, dwell; commits new digits only between frames.
module seg7_scan_scheduler #(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit COMMON_ANODE   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    update_i,
  output logic                    update_ack_o,
  output logic                    shift_trigger_o,
  output logic [15:0]             shift_data_o,
  input  logic                    shift_done_i,
  output logic [2:0]              digit_idx_o,
  output logic                    frame_done_o,
  output logic                    timeout_err_o
);

  localparam int DCW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [15:0]    BLANK_WORD = COMMON_ANODE ? 16'hFFFF : 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_DWELL,
    S_BLANK
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] slot_word(input logic [3:0] v, input logic dp,
                                            input logic [2:0] i);
    logic [15:0] w;
    w = {dp, seg_decode(v), 8'b1 << i};
    return COMMON_ANODE ? ~w : w;
  endfunction

  state_t state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [DCW-1:0] dcnt;
  logic [TCW-1:0] tcnt;
  logic blanking;

  logic [4*NUM_DIGITS-1:0] digit_buf, stage_digits, nxt_digits;
  logic [NUM_DIGITS-1:0]   dp_buf, stage_dp, nxt_dp;
  logic pend;

  logic load_word, load_blank, commit, frame_end, tmo_hit;
  logic req, tmo, dwell_end, last, wait_exit;
  logic [31:0] dig_pad;
  logic [7:0]  dp_pad;
  logic [15:0] word_nxt;

  assign req       = update_i | pend;
  assign tmo       = (tcnt == TMO_LAST);
  assign dwell_end = (dcnt == DWELL_LAST);
  assign last      = (idx == IDX_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    load_word  = 1'b0;
    load_blank = 1'b0;
    commit     = 1'b0;
    frame_end  = 1'b0;
    tmo_hit    = 1'b0;
    wait_exit  = 1'b0;
    case (state)
      S_IDLE: begin
        commit = req;
        if (enable_i) begin
          state_nxt = S_LOAD;
          idx_nxt   = 3'd0;
          load_word = 1'b1;
        end
      end
      S_LOAD, S_BLANK: state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!shift_done_i) state_nxt = S_WAIT_HIGH;
        else if (tmo) begin
          tmo_hit   = 1'b1;
          wait_exit = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (shift_done_i) wait_exit = 1'b1;
        else if (tmo) begin
          tmo_hit   = 1'b1;
          wait_exit = 1'b1;
        end
      end
      S_DWELL: begin
        if (dwell_end) begin
          if (!last) begin
            idx_nxt   = idx + 3'd1;
            state_nxt = S_LOAD;
            load_word = 1'b1;
          end else begin
            frame_end = 1'b1;
            idx_nxt   = 3'd0;
            commit    = req;
            if (enable_i) begin
              state_nxt = S_LOAD;
              load_word = 1'b1;
            end else begin
              state_nxt  = S_BLANK;
              load_blank = 1'b1;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A blanking shift returns to idle instead of dwelling
    if (wait_exit) state_nxt = blanking ? S_IDLE : S_DWELL;
  end

  // Word is built from the post-commit buffer so a boundary commit shows on digit 0 at once
  always_comb begin
    nxt_digits = digit_buf;
    nxt_dp     = dp_buf;
    if (commit) begin
      nxt_digits = update_i ? digits_i : stage_digits;
      nxt_dp     = update_i ? dp_i : stage_dp;
    end
    dig_pad  = 32'(nxt_digits);
    dp_pad   = 8'(nxt_dp);
    word_nxt = slot_word(dig_pad[{idx_nxt, 2'b00} +: 4], dp_pad[idx_nxt], idx_nxt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx             <= 3'd0;
      shift_trigger_o <= 1'b0;
      shift_data_o    <= 16'h0000;
      update_ack_o    <= 1'b0;
      frame_done_o    <= 1'b0;
      timeout_err_o   <= 1'b0;
      blanking        <= 1'b0;
      tcnt            <= '0;
      dcnt            <= '0;
      digit_buf       <= '0;
      dp_buf          <= '0;
      stage_digits    <= '0;
      stage_dp        <= '0;
      pend            <= 1'b0;
    end else begin
      idx             <= idx_nxt;
      shift_trigger_o <= load_word | load_blank;
      update_ack_o    <= commit;
      frame_done_o    <= frame_end;
      if (tmo_hit) timeout_err_o <= 1'b1;
      if (load_word)       shift_data_o <= word_nxt;
      else if (load_blank) shift_data_o <= BLANK_WORD;
      if (load_word | load_blank) blanking <= load_blank;
      // Counter starts at 1 so it equals cycles elapsed since the trigger
      if (state == S_LOAD || state == S_BLANK)               tcnt <= TCW'(1);
      else if (state == S_WAIT_LOW || state == S_WAIT_HIGH) tcnt <= tcnt + TCW'(1);
      if (state == S_DWELL) dcnt <= dcnt + DCW'(1);
      else                  dcnt <= '0;
      if (commit) begin
        digit_buf <= nxt_digits;
        dp_buf    <= nxt_dp;
        pend      <= 1'b0;
      end else if (update_i) begin
        stage_digits <= digits_i;
        stage_dp     <= dp_i;
        pend         <= 1'b1;
      end
    end
  end

  assign digit_idx_o = idx;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Directed bench for seg7_scan_scheduler: frame words, dwell timing, buffered commits,
// enable drop, shifter timeout, async reset and common-anode polarity.
module tb_seg7_scan_scheduler;
  localparam int D     = 5;
  localparam int TMO   = 64;
  localparam int SHIFT = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, update = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0] dp = '0;
  logic ack, trig, done, fdone, err;
  logic [15:0] data;
  logic [2:0] idx;

  logic enable2 = 1'b0, update2 = 1'b0;
  logic [15:0] digits2 = '0;
  logic [3:0] dp2 = '0;
  logic ack2, trig2, done2, fdone2, err2;
  logic [15:0] data2;
  logic [2:0] idx2;

  int busy = 0, busy2 = 0, cyc = 0;
  bit force_high = 1'b0;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (trig) busy <= SHIFT;
    else if (busy > 0) busy <= busy - 1;
    if (trig2) busy2 <= 3;
    else if (busy2 > 0) busy2 <= busy2 - 1;
  end
  assign done  = force_high | (busy == 0);
  assign done2 = (busy2 == 0);

  seg7_scan_scheduler #(.NUM_DIGITS(4), .DWELL_CYCLES(D), .TIMEOUT_CYCLES(TMO),
                        .COMMON_ANODE(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .digits_i(digits), .dp_i(dp),
    .update_i(update), .update_ack_o(ack), .shift_trigger_o(trig), .shift_data_o(data),
    .shift_done_i(done), .digit_idx_o(idx), .frame_done_o(fdone), .timeout_err_o(err));

  seg7_scan_scheduler #(.NUM_DIGITS(4), .DWELL_CYCLES(D), .TIMEOUT_CYCLES(TMO),
                        .COMMON_ANODE(1'b1)) u_ca (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable2), .digits_i(digits2), .dp_i(dp2),
    .update_i(update2), .update_ack_o(ack2), .shift_trigger_o(trig2), .shift_data_o(data2),
    .shift_done_i(done2), .digit_idx_o(idx2), .frame_done_o(fdone2), .timeout_err_o(err2));

  typedef struct packed {
    logic [15:0]      digits;
    logic [3:0]       dp;
    logic [3:0][15:0] w;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit sel(input int which);
    case (which)
      0: return trig;
      1: return fdone;
      2: return !done;
      3: return done;
      4: return err;
      5: return trig2;
      6: return fdone2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sel(which)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic do_slot(input logic [15:0] w, input int s, input bit here,
                         input int exp_at, output int dh);
    int at;
    if (!here) begin
      wait_sig(0, 500, at);
      check($sformatf("trig_cycle_s%0d", s), at, exp_at);
    end
    check($sformatf("word_s%0d", s), int'(data), int'(w));
    check($sformatf("idx_s%0d", s), int'(idx), s);
    wait_sig(2, 10, at);
    wait_sig(3, 100, dh);
  endtask

  task automatic commit_idle(input logic [15:0] dg, input logic [3:0] d);
    @(negedge clk);
    digits = dg;
    dp     = d;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    check("idle_ack", int'(ack), 1);
  endtask

  initial begin
    int at, c, dh, lt;
    tbl[0] = '{16'h1234, 4'b0000, {16'h0608, 16'h5B04, 16'h4F02, 16'h6601}};
    tbl[1] = '{16'hABCD, 4'b0001, {16'h7708, 16'h7C04, 16'h3902, 16'hDE01}};
    tbl[2] = '{16'h9876, 4'b1010, {16'hEF08, 16'h7F04, 16'h8702, 16'h7D01}};
    tbl[3] = '{16'hF0E5, 4'b0100, {16'h7108, 16'hBF04, 16'h7902, 16'h6D01}};

    // Reset values on both polarities
    repeat (3) @(negedge clk);
    check("rst_trig", int'(trig), 0);
    check("rst_data", int'(data), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_fdone", int'(fdone), 0);
    check("rst_err", int'(err), 0);
    check("rst_data_ca", int'(data2), 0);
    rst_n = 1'b1;

    // Common-anode: digit 8 with dp on slot 0, blank word all ones
    @(negedge clk);
    digits2 = 16'h0008;
    dp2 = 4'b0001;
    update2 = 1'b1;
    @(negedge clk);
    update2 = 1'b0;
    enable2 = 1'b1;
    wait_sig(5, 10, at);
    enable2 = 1'b0;
    check("ca_word_s0", int'(data2), 16'h00FE);
    wait_sig(6, 500, at);
    check("ca_blank_trig", int'(trig2), 1);
    check("ca_blank_word", int'(data2), 16'hFFFF);

    // Table: one frame per vector, enable pulsed once, frame ends in blank then idle
    for (int v = 0; v < 4; v++) begin
      commit_idle(tbl[v].digits, tbl[v].dp);
      enable = 1'b1;
      c = cyc;
      wait_sig(0, 10, at);
      enable = 1'b0;
      check("first_trig_latency", at, c + 1);
      dh = 0;
      for (int s = 0; s < 4; s++) do_slot(tbl[v].w[s], s, s == 0, dh + D + 1, dh);
      wait_sig(1, 50, at);
      check("fdone_cycle", at, dh + D + 1);
      check("blank_trig", int'(trig), 1);
      check("blank_word", int'(data), 0);
      check("fdone_no_ack", int'(ack), 0);
      wait_sig(0, 120, at);
      check("idle_no_trig", at, -1);
    end

    // Mid-frame update pulse, then enable dropped during digit 1 of the next frame
    commit_idle(16'h1234, 4'b0000);
    enable = 1'b1;
    wait_sig(0, 10, at);
    do_slot(16'h6601, 0, 1'b1, 0, dh);
    do_slot(16'h4F02, 1, 1'b0, dh + D + 1, dh);
    @(negedge clk);
    digits = 16'hABCD;
    dp = 4'b0001;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    digits = 16'h5555;
    dp = 4'b0000;
    check("mid_frame_no_ack", int'(ack), 0);
    do_slot(16'h5B04, 2, 1'b0, dh + D + 1, dh);
    do_slot(16'h0608, 3, 1'b0, dh + D + 1, dh);
    wait_sig(1, 50, at);
    check("fdone_cycle_upd", at, dh + D + 1);
    check("ack_with_fdone", int'(ack), 1);
    check("next_frame_trig", int'(trig), 1);
    do_slot(16'hDE01, 0, 1'b1, 0, dh);
    do_slot(16'h3902, 1, 1'b0, dh + D + 1, dh);
    enable = 1'b0;
    do_slot(16'h7C04, 2, 1'b0, dh + D + 1, dh);
    do_slot(16'h7708, 3, 1'b0, dh + D + 1, dh);
    wait_sig(1, 50, at);
    check("drop_fdone_cycle", at, dh + D + 1);
    check("drop_blank_word", int'(data), 0);
    check("drop_blank_trig", int'(trig), 1);
    wait_sig(0, 120, at);
    check("drop_idle_no_trig", at, -1);

    // Shifter never starts: sticky timeout, scanning continues
    force_high = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    c = cyc;
    wait_sig(0, 10, lt);
    enable = 1'b0;
    check("tmo_trig_latency", lt, c + 1);
    check("tmo_err_before", int'(err), 0);
    wait_sig(4, 200, at);
    check("tmo_err_cycle", at, lt + TMO);
    wait_sig(0, 200, at);
    check("tmo_next_trig", at, lt + TMO + D);
    check("tmo_idx_next", int'(idx), 1);
    wait_sig(1, 1000, at);
    check("tmo_fdone_seen", int'(at >= 0), 1);
    wait_sig(0, 200, at);
    check("tmo_idle_no_trig", at, -1);
    check("tmo_err_sticky", int'(err), 1);
    force_high = 1'b0;

    // Async reset during WAIT_HIGH of slot 1, restart with enable held
    enable = 1'b1;
    wait_sig(0, 10, at);
    wait_sig(0, 500, at);
    wait_sig(2, 10, at);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("amid_trig", int'(trig), 0);
    check("amid_data", int'(data), 0);
    check("amid_idx", int'(idx), 0);
    check("amid_err", int'(err), 0);
    check("amid_fdone", int'(fdone), 0);
    check("amid_ack", int'(ack), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    wait_sig(0, 10, at);
    check("post_rst_latency", at, c + 1);
    check("post_rst_idx", int'(idx), 0);
    check("post_rst_word", int'(data), 16'h3F01);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
